// File: rtl/mem_arbiter.sv
// Three-way IF/LD/ST arbiter in front of a single level-held memory port.
// Define ARB_FAIRNESS_EN to bound how long IF can be starved by data traffic.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STREAK_MAX = 4,
  parameter int STREAK_W   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_length,
  input  logic                  ld_signed,
  output logic                  ld_ready,
  output logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  st_req,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_length,
  output logic                  st_ready,
  output logic                  dn_read,
  output logic                  dn_write,
  output logic [ADDR_WIDTH-1:0] dn_addr,
  output logic [DATA_WIDTH-1:0] dn_wdata,
  output logic [2:0]            dn_length,
  output logic                  dn_signed,
  input  logic                  dn_ready,
  input  logic [DATA_WIDTH-1:0] dn_rdata,
  output logic                  busy,
  output logic                  err_len
);

  typedef enum logic [2:0] {
    IDLE, GNT_IF, GNT_LD, GNT_ST, GAP
  } state_t;

  state_t state, state_nxt;
  logic   drop;
  logic   if_elig, fair;
  logic   g_if, g_ld, g_st;
  logic   ld_ok, st_ok;

  function automatic logic len_ok(input logic [2:0] len);
    return (len == 3'd1) || (len == 3'd2) || (len == 3'd4);
  endfunction

  assign if_elig = if_req && !if_flush;
  assign ld_ok   = len_ok(ld_length);
  assign st_ok   = len_ok(st_length);

`ifdef ARB_FAIRNESS_EN
  logic [STREAK_W-1:0] streak;
  assign fair = if_elig && (streak == STREAK_W'(STREAK_MAX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (g_if || !if_req)
        streak <= '0;
      else if ((g_st || g_ld) && if_elig &&
               streak != STREAK_W'(STREAK_MAX))
        streak <= streak + STREAK_W'(1);
    end
  end
`else
  // Constant 0; only references the streak parameters.
  assign fair = (STREAK_MAX < 0) && (STREAK_W < 0);
`endif

  // One-hot winner: fairness override, then ST > LD > IF.
  assign g_st = st_req && !fair;
  assign g_ld = ld_req && !st_req && !fair;
  assign g_if = if_elig && (fair || (!st_req && !ld_req));

  assign busy = (state == GNT_IF) || (state == GNT_LD) ||
                (state == GNT_ST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          g_st:    state_nxt = st_ok ? GNT_ST : GAP;
          g_ld:    state_nxt = ld_ok ? GNT_LD : GAP;
          g_if:    state_nxt = GNT_IF;
          default: state_nxt = IDLE;
        endcase
      end
      GNT_IF, GNT_LD, GNT_ST: begin
        if (dn_ready) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A flush during a fetch only suppresses its result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      drop <= 1'b0;
    else if (state == GNT_IF && !dn_ready)
      drop <= drop || if_flush;
    else
      drop <= 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dn_read   <= 1'b0;
      dn_write  <= 1'b0;
      dn_addr   <= '0;
      dn_wdata  <= '0;
      dn_length <= '0;
      dn_signed <= 1'b0;
      if_ready  <= 1'b0;
      ld_ready  <= 1'b0;
      st_ready  <= 1'b0;
      if_data   <= '0;
      ld_data   <= '0;
      err_len   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      ld_ready <= 1'b0;
      st_ready <= 1'b0;
      case (state)
        IDLE: begin
          unique case (1'b1)
            g_st: begin
              if (st_ok) begin
                dn_write  <= 1'b1;
                dn_addr   <= st_addr;
                dn_wdata  <= st_data;
                dn_length <= st_length;
                dn_signed <= 1'b0;
              end else begin
                st_ready <= 1'b1;
                err_len  <= 1'b1;
              end
            end
            g_ld: begin
              if (ld_ok) begin
                dn_read   <= 1'b1;
                dn_addr   <= ld_addr;
                dn_wdata  <= '0;
                dn_length <= ld_length;
                dn_signed <= ld_signed;
              end else begin
                ld_ready <= 1'b1;
                ld_data  <= '0;
                err_len  <= 1'b1;
              end
            end
            g_if: begin
              dn_read   <= 1'b1;
              dn_addr   <= if_addr;
              dn_wdata  <= '0;
              dn_length <= 3'd4;
              dn_signed <= 1'b0;
            end
            default: ;
          endcase
        end
        GNT_IF: begin
          if (dn_ready) begin
            dn_read <= 1'b0;
            if (!(drop || if_flush)) begin
              if_ready <= 1'b1;
              if_data  <= dn_rdata;
            end
          end
        end
        GNT_LD: begin
          if (dn_ready) begin
            dn_read  <= 1'b0;
            ld_ready <= 1'b1;
            ld_data  <= dn_rdata;
          end
        end
        GNT_ST: begin
          if (dn_ready) begin
            dn_write <= 1'b0;
            st_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction-fetch stage, the MEM stage and the byte-serial memory controller, which has exactly one level-held request port.
- Arbitrates three requesters: instruction fetch (IF), data load (LD) and data store (ST).
- Holds the winner's request stable until the controller's ready pulse, then routes the result back to that requester.
- Handles fetch flushes and rejects illegal access lengths, so the controller only sees clean, stable transactions.

Parameters:
- ADDR_WIDTH, 32, address width of all requester and downstream address buses.
- DATA_WIDTH, 32, data width of all requester and downstream data buses.
- STREAK_MAX, 4, number of consecutive data grants allowed while IF waits (used only with the fairness feature).
- STREAK_W, 3, counter width; must satisfy 2^STREAK_W > STREAK_MAX.

Ports:
- clock  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level-held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address; length is always 4.
- if_flush  in  1  branch flush; discards the fetch in flight.
- if_ready  out  1  one-cycle pulse: if_data valid.
- if_data  out  DATA_WIDTH  fetched word.
- ld_req  in  1  load request, level-held.
- ld_addr  in  ADDR_WIDTH  load address.
- ld_length  in  3  load length in bytes: 1, 2 or 4.
- ld_signed  in  1  sign-extend the load result.
- ld_ready  out  1  one-cycle pulse: ld_data valid.
- ld_data  out  DATA_WIDTH  load result.
- st_req  in  1  store request, level-held.
- st_addr  in  ADDR_WIDTH  store address.
- st_data  in  DATA_WIDTH  store data, low bytes first.
- st_length  in  3  store length in bytes: 1, 2 or 4.
- st_ready  out  1  one-cycle pulse: store done.
- dn_read  out  1  downstream read request.
- dn_write  out  1  downstream write request.
- dn_addr  out  ADDR_WIDTH  downstream address.
- dn_wdata  out  DATA_WIDTH  downstream write data.
- dn_length  out  3  downstream access length.
- dn_signed  out  1  downstream sign-extend flag.
- dn_ready  in  1  downstream completion pulse.
- dn_rdata  in  DATA_WIDTH  downstream read data, valid with dn_ready.
- busy  out  1  a transaction is outstanding.
- err_len  out  1  sticky illegal-length flag; cleared only by reset.

Behaviour:
- States: IDLE, GNT_IF, GNT_LD, GNT_ST, GAP.
- Reset (asynchronous, reset=0):
  - State goes to IDLE and the streak counter to 0.
  - dn_read, dn_write, all *_ready, busy and err_len go to 0.
  - if_data, ld_data, dn_addr, dn_wdata, dn_length and dn_signed go to 0.
  - Reset during a transfer abandons it; the downstream controller is reset by the same net.
- IDLE: each cycle, select a winner among eligible requests. The winner's fields are registered into the dn_* outputs and the state moves to GNT_x at the next edge.
- Priority: ST > LD > IF.
- IF eligibility: IF is not eligible in a cycle where if_flush=1.
- GNT_x: dn_read/dn_write and all dn_* fields stay constant until dn_ready=1. At the dn_ready edge:
  - dn_read and dn_write are cleared.
  - The matching *_ready pulses for exactly one cycle. For loads and fetches, ld_data/if_data are latched from dn_rdata.
  - The state moves to GAP.
- GAP: one idle cycle so the requester can drop its req; no grant is made. Then IDLE.
- Minimum transaction: IDLE → GNT_x costs 1 cycle, plus the downstream latency, plus 1 GAP cycle.
- dn_ready in IDLE or GAP is ignored.
- if_flush while in GNT_IF: a drop flag is set and the transfer runs to completion (the downstream cannot abort). At dn_ready, if_ready stays 0 and if_data is unchanged. The flag clears on leaving GNT_IF.
- if_flush in any other state has no effect beyond eligibility in IDLE.
- Illegal length (ld_length or st_length not in {1,2,4}) on the winning data request:
  - No downstream access is made.
  - The matching *_ready pulses the next cycle; ld_data becomes 0.
  - err_len is set; the state goes to GAP.
- Simultaneous ld_req and st_req: ST wins, so a load issued in the same cycle sees the stored value.
- Requests changing while not granted are not sampled.
- A requester dropping req mid-grant does not stop the transfer; its *_ready still pulses.
- busy = 1 in GNT_IF, GNT_LD and GNT_ST.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - The streak counter increments on each LD/ST grant made while if_req=1 and if_flush=0.
  - It resets to 0 on any IF grant, or on an IDLE cycle with if_req=0.
  - When the counter equals STREAK_MAX and IF is eligible, IF wins over LD and ST.
  - The counter saturates at STREAK_MAX.
- Undefined: strict ST > LD > IF priority; no counter logic is synthesised.

Test Plan:
- if_req only, addr 0x1000, downstream ready after 5 cycles with rdata 0xDEADBEEF → dn_read held with dn_addr=0x1000 and dn_length=4; one-cycle if_ready with if_data=0xDEADBEEF; busy then drops; one GAP cycle.
- st_req, ld_req and if_req raised the same cycle → grant order ST, LD, IF; each pulses *_ready once; one GAP cycle between grants.
- if_req granted, if_flush pulsed 2 cycles later, dn_ready later → no if_ready, if_data unchanged; next request granted normally.
- ld_length=3 → no dn_read; ld_ready pulse with ld_data=0; err_len=1 until reset.
- With ARB_FAIRNESS_EN and STREAK_MAX=4: continuous ld_req plus if_req → 4 LD grants, 1 IF grant, repeating. Without the macro → IF starves.
- Reset asserted mid GNT_LD → all outputs 0 immediately, state IDLE; after release, a pending ld_req is re-granted from the start.
